// File: rtl/memory_access_unit.sv
// Single-outstanding load/store unit between the pipeline and a split address/data bus.
// Supports aligned accesses plus LEFT/RIGHT partial-word store strobing and load merging.
module memory_access_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_msize,
    input  logic [1:0]              req_mode,
    input  logic                    req_signed,
    input  logic [31:0]             req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic                    flush,
    output logic                    dreq_valid,
    output logic [31:0]             dreq_addr,
    output logic [1:0]              dreq_size,
    output logic [DATA_WIDTH/8-1:0] dreq_strobe,
    output logic [DATA_WIDTH-1:0]   dreq_data,
    input  logic                    addr_ok,
    input  logic                    data_ok,
    input  logic [DATA_WIDTH-1:0]   rdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_data,
    output logic                    resp_exc
);
    localparam int B  = DATA_WIDTH / 8;
    localparam int OW = $clog2(B);
    localparam logic [DATA_WIDTH-1:0] ONES = '1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t state, state_next;
    logic   killed;

    logic                  write_p0;
    logic                  signed_p0;
    logic [1:0]            msize_p0;
    logic [1:0]            mode_p0;
    logic [DATA_WIDTH-1:0] wdata_p0;

    logic                  accept;
    logic                  capture;
    logic                  misaligned;
    logic [OW-1:0]         req_off;
    logic [OW-1:0]         align_mask;

    function automatic logic [B-1:0] store_strobe(input logic [1:0] mode,
                                                  input logic [1:0] msize,
                                                  input logic [OW-1:0] o);
        logic [15:0] s;
        case (mode)
            2'b01:   s = (16'd2 << o) - 16'd1;
            2'b10:   s = 16'hFFFF << o;
            default: s = ((16'd1 << (4'd1 << msize)) - 16'd1) << o;
        endcase
        return s[B-1:0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] store_align(input logic [1:0] mode,
                                                          input logic [DATA_WIDTH-1:0] wdata,
                                                          input logic [OW-1:0] o);
        if (mode == 2'b01)
            return wdata >> {~o, 3'b000};
        return wdata << {o, 3'b000};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] v,
                                                     input logic [1:0] msize,
                                                     input logic sgn);
        logic signed [7:0]            b8;
        logic signed [15:0]           h16;
        logic signed [31:0]           w32;
        logic signed [DATA_WIDTH-1:0] r;
        b8  = v[7:0];
        h16 = v[15:0];
        w32 = v[31:0];
        r   = v;
        case (msize)
            2'd0:    r = sgn ? DATA_WIDTH'(b8)  : DATA_WIDTH'(v[7:0]);
            2'd1:    r = sgn ? DATA_WIDTH'(h16) : DATA_WIDTH'(v[15:0]);
            2'd2:    r = sgn ? DATA_WIDTH'(w32) : DATA_WIDTH'(v[31:0]);
            default: r = v;
        endcase
        return r;
    endfunction

    // LEFT/RIGHT loads overlay the fetched bytes onto the old register value.
    function automatic logic [DATA_WIDTH-1:0] load_result(input logic [1:0] mode,
                                                          input logic [1:0] msize,
                                                          input logic sgn,
                                                          input logic [OW-1:0] o,
                                                          input logic [DATA_WIDTH-1:0] rd,
                                                          input logic [DATA_WIDTH-1:0] old);
        logic [DATA_WIDTH-1:0] keep;
        keep = '0;
        case (mode)
            2'b01: begin
                keep = ~(ONES << {~o, 3'b000});
                return (rd << {~o, 3'b000}) | (old & keep);
            end
            2'b10: begin
                keep = ~(ONES >> {o, 3'b000});
                return (rd >> {o, 3'b000}) | (old & keep);
            end
            default: return extend(rd >> {o, 3'b000}, msize, sgn);
        endcase
    endfunction

    assign req_ready  = (state == IDLE);
    assign dreq_valid = (state == ADDR);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;
    assign capture    = (state == ADDR && addr_ok && data_ok) || (state == DATA && data_ok);

    assign req_off    = req_addr[OW-1:0];
    assign align_mask = OW'((4'd1 << req_msize) - 4'd1);
    assign misaligned = (req_mode == 2'b11)
                     || (B == 4 && req_msize == 2'b11)
                     || (req_mode == 2'b00 && (req_off & align_mask) != '0);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = misaligned ? RESP : ADDR;
            ADDR: if (addr_ok) begin
                if (!data_ok)
                    state_next = DATA;
                else
                    state_next = (killed || flush) ? IDLE : RESP;
            end
            DATA: if (data_ok) state_next = (killed || flush) ? IDLE : RESP;
            RESP: if (resp_ready || flush) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            killed <= 1'b0;
        end else begin
            state  <= state_next;
            killed <= (state == ADDR || state == DATA)
                   && (state_next == ADDR || state_next == DATA)
                   && (killed || flush);
        end
    end

    // Request capture stage: fields the bus and merge logic need later.
    always_ff @(posedge clk) begin
        if (accept) begin
            write_p0  <= req_write;
            signed_p0 <= req_signed;
            msize_p0  <= req_msize;
            mode_p0   <= req_mode;
            wdata_p0  <= req_wdata;
        end
    end

    // Bus-visible and response registers must read zero while reset is held.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dreq_addr   <= '0;
            dreq_size   <= '0;
            dreq_strobe <= '0;
            dreq_data   <= '0;
            resp_data   <= '0;
            resp_exc    <= 1'b0;
        end else if (accept) begin
            dreq_addr   <= req_addr;
            dreq_size   <= (req_mode == 2'b00) ? req_msize : 2'(OW);
            dreq_strobe <= req_write ? store_strobe(req_mode, req_msize, req_off) : '0;
            dreq_data   <= req_write ? store_align(req_mode, req_wdata, req_off) : '0;
            resp_data   <= '0;
            resp_exc    <= misaligned;
        end else if (capture) begin
            resp_data <= write_p0 ? '0
                       : load_result(mode_p0, msize_p0, signed_p0, dreq_addr[OW-1:0], rdata, wdata_p0);
        end
    end
endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: 32-bit instance for most cases, 64-bit for doubleword.
module tb_memory_access_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;
    logic req_valid, req_write, req_signed, flush, addr_ok, data_ok, resp_ready;
    logic [1:0]  req_msize, req_mode;
    logic [31:0] req_addr, req_wdata, rdata;
    logic req_ready, dreq_valid, resp_valid, resp_exc;
    logic [31:0] dreq_addr, dreq_data, resp_data;
    logic [1:0]  dreq_size;
    logic [3:0]  dreq_strobe;

    logic x_req_valid, x_req_write, x_req_signed, x_flush, x_addr_ok, x_data_ok, x_resp_ready;
    logic [1:0]  x_req_msize, x_req_mode;
    logic [31:0] x_req_addr;
    logic [63:0] x_req_wdata, x_rdata;
    logic x_req_ready, x_dreq_valid, x_resp_valid, x_resp_exc;
    logic [31:0] x_dreq_addr;
    logic [63:0] x_dreq_data, x_resp_data;
    logic [1:0]  x_dreq_size;
    logic [7:0]  x_dreq_strobe;

    int checks = 0;
    int errors = 0;

    memory_access_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_msize(req_msize), .req_mode(req_mode),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data), .addr_ok(addr_ok), .data_ok(data_ok),
        .rdata(rdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_exc(resp_exc)
    );

    memory_access_unit #(.DATA_WIDTH(64)) dut64 (
        .clk(clk), .resetn(resetn), .req_valid(x_req_valid), .req_ready(x_req_ready),
        .req_write(x_req_write), .req_msize(x_req_msize), .req_mode(x_req_mode),
        .req_signed(x_req_signed), .req_addr(x_req_addr), .req_wdata(x_req_wdata), .flush(x_flush),
        .dreq_valid(x_dreq_valid), .dreq_addr(x_dreq_addr), .dreq_size(x_dreq_size),
        .dreq_strobe(x_dreq_strobe), .dreq_data(x_dreq_data), .addr_ok(x_addr_ok), .data_ok(x_data_ok),
        .rdata(x_rdata), .resp_valid(x_resp_valid), .resp_ready(x_resp_ready),
        .resp_data(x_resp_data), .resp_exc(x_resp_exc)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [1:0] ms, input logic [1:0] md,
                         input logic sg, input logic [31:0] ad, input logic [31:0] wd);
        check("ready_before_issue", 64'(req_ready), 1);
        req_valid = 1'b1; req_write = wr; req_msize = ms; req_mode = md;
        req_signed = sg; req_addr = ad; req_wdata = wd;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic bus(input logic [31:0] rd, input logic same);
        addr_ok = 1'b1; data_ok = same; rdata = rd;
        tick();
        addr_ok = 1'b0;
        if (!same) begin
            check("dreq_valid_in_data", 64'(dreq_valid), 0);
            data_ok = 1'b1;
            tick();
        end
        data_ok = 1'b0;
    endtask

    task automatic take_resp(input string tag, input logic [31:0] exp_data, input logic exp_exc);
        check({tag, "_valid"}, 64'(resp_valid), 1);
        check({tag, "_data"}, 64'(resp_data), 64'(exp_data));
        check({tag, "_exc"}, 64'(resp_exc), 64'(exp_exc));
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check({tag, "_idle"}, 64'(req_ready), 1);
    endtask

    initial begin
        resetn = 1'b0;
        req_valid = 0; req_write = 0; req_signed = 0; flush = 0; addr_ok = 0; data_ok = 0;
        resp_ready = 0; req_msize = 0; req_mode = 0; req_addr = 0; req_wdata = 0; rdata = 0;
        x_req_valid = 0; x_req_write = 0; x_req_signed = 0; x_flush = 0; x_addr_ok = 0;
        x_data_ok = 0; x_resp_ready = 0; x_req_msize = 0; x_req_mode = 0; x_req_addr = 0;
        x_req_wdata = 0; x_rdata = 0;
        #12;
        check("rst_req_ready", 64'(req_ready), 1);
        check("rst_dreq_valid", 64'(dreq_valid), 0);
        check("rst_resp_valid", 64'(resp_valid), 0);
        check("rst_dreq_addr", 64'(dreq_addr), 0);
        resetn = 1'b1;
        tick();

        // Byte store at offset 3, with the bus stalling addr_ok for one cycle.
        issue(1, 2'd0, 2'd0, 0, 32'h3, 32'hAB);
        check("sb_dreq_valid", 64'(dreq_valid), 1);
        check("sb_strobe", 64'(dreq_strobe), 64'h8);
        check("sb_data", 64'(dreq_data), 64'hAB000000);
        check("sb_addr", 64'(dreq_addr), 64'h3);
        check("sb_size", 64'(dreq_size), 0);
        tick();
        check("sb_hold_valid", 64'(dreq_valid), 1);
        check("sb_hold_data", 64'(dreq_data), 64'hAB000000);
        bus(32'h0, 0);
        take_resp("sb", 32'h0, 0);

        issue(1, 2'd2, 2'd1, 0, 32'h1, 32'h11223344);
        check("swl_strobe", 64'(dreq_strobe), 64'h3);
        check("swl_data", 64'(dreq_data), 64'h00001122);
        check("swl_size", 64'(dreq_size), 2);
        bus(32'h0, 0);
        take_resp("swl", 32'h0, 0);

        issue(1, 2'd2, 2'd2, 0, 32'h1, 32'h11223344);
        check("swr_strobe", 64'(dreq_strobe), 64'hE);
        check("swr_data", 64'(dreq_data), 64'h22334400);
        bus(32'h0, 1);
        take_resp("swr", 32'h0, 0);

        // Signed halfword load, same-cycle addr_ok/data_ok, response stalled 3 cycles.
        issue(0, 2'd1, 2'd0, 1, 32'h2, 32'h0);
        check("lh_strobe", 64'(dreq_strobe), 0);
        check("lh_size", 64'(dreq_size), 1);
        check("lh_addr", 64'(dreq_addr), 64'h2);
        bus(32'h8001_0000, 1);
        for (int i = 0; i < 3; i++) begin
            check("lh_stall_valid", 64'(resp_valid), 1);
            check("lh_stall_data", 64'(resp_data), 64'hFFFF8001);
            tick();
        end
        take_resp("lh", 32'hFFFF8001, 0);

        issue(0, 2'd0, 2'd0, 1, 32'h1, 32'h0);
        bus(32'h12349956, 0);
        take_resp("lb", 32'hFFFFFF99, 0);

        issue(0, 2'd0, 2'd0, 0, 32'h3, 32'h0);
        bus(32'h80000000, 1);
        take_resp("lbu", 32'h00000080, 0);

        issue(0, 2'd2, 2'd0, 0, 32'h0, 32'h0);
        bus(32'hDEADBEEF, 0);
        take_resp("lw", 32'hDEADBEEF, 0);

        issue(0, 2'd2, 2'd1, 0, 32'h1, 32'hAABBCCDD);
        bus(32'h44332211, 1);
        take_resp("lwl", 32'h2211CCDD, 0);

        issue(0, 2'd2, 2'd2, 0, 32'h1, 32'hAABBCCDD);
        bus(32'h44332211, 0);
        take_resp("lwr", 32'hAA443322, 0);

        // Address errors: no bus request, immediate exception response.
        issue(0, 2'd1, 2'd0, 1, 32'h1, 32'h0);
        check("mis_lh_no_dreq", 64'(dreq_valid), 0);
        take_resp("mis_lh", 32'h0, 1);
        issue(0, 2'd2, 2'd3, 0, 32'h0, 32'h0);
        take_resp("mis_mode", 32'h0, 1);
        issue(1, 2'd3, 2'd0, 0, 32'h0, 32'h5);
        check("mis_d32_no_dreq", 64'(dreq_valid), 0);
        take_resp("mis_d32", 32'h0, 1);

        // Flush while waiting for data: bus completes, response is dropped.
        issue(0, 2'd2, 2'd0, 0, 32'h0, 32'h0);
        addr_ok = 1'b1;
        tick();
        addr_ok = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("kill_wait_ready", 64'(req_ready), 0);
        check("kill_wait_resp", 64'(resp_valid), 0);
        data_ok = 1'b1; rdata = 32'h5555AAAA;
        tick();
        data_ok = 1'b0;
        check("kill_resp", 64'(resp_valid), 0);
        check("kill_ready", 64'(req_ready), 1);
        tick();
        check("kill_resp_later", 64'(resp_valid), 0);

        issue(0, 2'd1, 2'd0, 0, 32'h3, 32'h0);
        check("flush_resp_pre", 64'(resp_valid), 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_resp_drop", 64'(resp_valid), 0);
        check("flush_resp_ready", 64'(req_ready), 1);

        // Flush coinciding with accept in IDLE must not kill the new access.
        flush = 1'b1;
        issue(0, 2'd2, 2'd0, 0, 32'h4, 32'h0);
        flush = 1'b0;
        bus(32'h00001234, 1);
        take_resp("flush_idle", 32'h00001234, 0);

        // Asynchronous reset mid-transaction.
        issue(1, 2'd2, 2'd0, 0, 32'h4, 32'h55);
        check("rst_mid_pre", 64'(dreq_valid), 1);
        #1 resetn = 1'b0;
        #1;
        check("rst_mid_dreq_valid", 64'(dreq_valid), 0);
        check("rst_mid_req_ready", 64'(req_ready), 1);
        check("rst_mid_strobe", 64'(dreq_strobe), 0);
        check("rst_mid_data", 64'(dreq_data), 0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        check("rst_mid_after", 64'(req_ready), 1);

        // 64-bit doubleword stores: misaligned then aligned.
        x_req_valid = 1'b1; x_req_write = 1'b1; x_req_msize = 2'd3; x_req_mode = 2'd0;
        x_req_addr = 32'h4; x_req_wdata = 64'h0102030405060708;
        tick();
        x_req_valid = 1'b0;
        check("d64_mis_valid", 64'(x_resp_valid), 1);
        check("d64_mis_exc", 64'(x_resp_exc), 1);
        check("d64_mis_no_dreq", 64'(x_dreq_valid), 0);
        x_resp_ready = 1'b1;
        tick();
        x_resp_ready = 1'b0;
        x_req_valid = 1'b1; x_req_addr = 32'h8;
        tick();
        x_req_valid = 1'b0;
        check("d64_dreq_valid", 64'(x_dreq_valid), 1);
        check("d64_strobe", 64'(x_dreq_strobe), 64'hFF);
        check("d64_data", x_dreq_data, 64'h0102030405060708);
        check("d64_size", 64'(x_dreq_size), 3);
        x_addr_ok = 1'b1; x_data_ok = 1'b1;
        tick();
        x_addr_ok = 1'b0; x_data_ok = 1'b0;
        check("d64_resp_valid", 64'(x_resp_valid), 1);
        check("d64_resp_exc", 64'(x_resp_exc), 0);
        check("d64_resp_data", x_resp_data, 64'h0);
        x_resp_ready = 1'b1;
        tick();
        x_resp_ready = 1'b0;
        check("d64_idle", 64'(x_req_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
